// File: rtl/idct4_pkg.sv
// Shared constants, width helpers and types for the 4-point inverse DCT pipe.
// The kernel is 64/83/36; sample vectors are four signed values, low to high.
package idct4_pkg;

  localparam int K64 = 64;
  localparam int K83 = 83;
  localparam int K36 = 36;

  localparam int DEF_W = 16;

  // Width that holds any butterfly sum plus the rounding offset.
  function automatic int iw(input int in_w);
    return in_w + 9;
  endfunction

  // Width of a single 83x or 36x product.
  function automatic int mcm_w(input int in_w);
    return in_w + 7;
  endfunction

  typedef logic signed [3:0][DEF_W-1:0] smp4_t;

endpackage

// File: rtl/idct4_mcm_83_36.sv
// Shift-add multiple-constant multiplier producing 83*x and 36*x.
// Purely combinational; one instance per odd coefficient.
module idct4_mcm_83_36
  import idct4_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic signed [IN_W-1:0]        x,
  output logic signed [mcm_w(IN_W)-1:0] x83,
  output logic signed [mcm_w(IN_W)-1:0] x36
);

  localparam int MW = mcm_w(IN_W);

  logic signed [MW-1:0] xe;

  assign xe  = MW'(x);
  // 83 = 64 + 16 + 2 + 1
  assign x83 = (xe <<< 6) + (xe <<< 4)
             + (xe <<< 1) + xe;
  // 36 = 32 + 4
  assign x36 = (xe <<< 5) + (xe <<< 2);

endmodule

// File: rtl/idct4_inv_pipe.sv
// Three-stage 4-point inverse DCT butterfly behind a valid/ready handshake.
// Define IDCT4_CLIP_EN to saturate outputs; otherwise they wrap to OUT_W.
module idct4_inv_pipe
  import idct4_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  c0,
  input  logic signed [IN_W-1:0]  c1,
  input  logic signed [IN_W-1:0]  c2,
  input  logic signed [IN_W-1:0]  c3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y0,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y2,
  output logic signed [OUT_W-1:0] y3
);

  localparam int IW = iw(IN_W);
  localparam int MW = mcm_w(IN_W);

  typedef logic signed [IW-1:0] wide_t;

  localparam wide_t RND  = wide_t'(1) <<< (SHIFT - 1);
  localparam wide_t MAXV = wide_t'((1 <<< (OUT_W - 1)) - 1);
  localparam wide_t MINV = wide_t'(-(1 <<< (OUT_W - 1)));

  // Range-limit a shifted sum to the output width.
  function automatic logic signed [OUT_W-1:0] lim(input wide_t v);
`ifdef IDCT4_CLIP_EN
    if (v > MAXV) return OUT_W'(MAXV);
    if (v < MINV) return OUT_W'(MINV);
    return OUT_W'(v);
`else
    return OUT_W'(v);
`endif
  endfunction

  logic en;

  logic signed [MW-1:0] m1_83;
  logic signed [MW-1:0] m1_36;
  logic signed [MW-1:0] m3_83;
  logic signed [MW-1:0] m3_36;

  wide_t c0w;
  wide_t c2w;

  logic  v1;
  wide_t e0;
  wide_t e1;
  wide_t o0;
  wide_t o1;

  logic  v2;
  wide_t s0;
  wide_t s1;
  wide_t s2;
  wide_t s3;

  // The whole pipe moves only when the output slot is free or draining,
  // so a stall freezes every stage and holds three beats in flight.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign c0w = wide_t'(c0);
  assign c2w = wide_t'(c2);

  idct4_mcm_83_36 #(
    .IN_W(IN_W)
  ) u_mcm_c1 (
    .x  (c1),
    .x83(m1_83),
    .x36(m1_36)
  );

  idct4_mcm_83_36 #(
    .IN_W(IN_W)
  ) u_mcm_c3 (
    .x  (c3),
    .x83(m3_83),
    .x36(m3_36)
  );

  // Stage 1: even and odd partial sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      e0 <= (c0w + c2w) <<< 6;
      e1 <= (c0w - c2w) <<< 6;
      o0 <= wide_t'(m1_83) + wide_t'(m3_36);
      o1 <= wide_t'(m1_36) - wide_t'(m3_83);
    end
  end

  // Stage 2: butterfly with the rounding offset folded in.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (en) begin
      v2 <= v1;
      s0 <= e0 + o0 + RND;
      s1 <= e1 + o1 + RND;
      s2 <= e1 - o1 + RND;
      s3 <= e0 - o0 + RND;
    end
  end

  // Stage 3: arithmetic shift and range limit onto the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y0        <= '0;
      y1        <= '0;
      y2        <= '0;
      y3        <= '0;
    end else if (en) begin
      out_valid <= v2;
      y0        <= lim(s0 >>> SHIFT);
      y1        <= lim(s1 >>> SHIFT);
      y2        <= lim(s2 >>> SHIFT);
      y3        <= lim(s3 >>> SHIFT);
    end
  end

endmodule

// File: doc/idct4_inv_pipe.md
Name: idct4_inv_pipe

Overview:
- 4-point inverse DCT-II butterfly: the inverse-transform counterpart of the forward 2-point odd-part multiplier block.
- Takes one column or row of 4 dequantised coefficients per transfer and returns 4 reconstructed residual samples.
- Uses the same 64/83/36 integer kernel, implemented with shift-add only (no multipliers).
- Sits in the inverse transform path between the dequantiser and the transpose buffer, behind a valid/ready handshake.

Parameters:
- IN_W, 16, signed coefficient width.
- OUT_W, 16, signed output sample width.
- SHIFT, 7, rounding right-shift; 7 for first stage, 20-bitdepth for second; legal range 1..12.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: synchronous, active-high reset.
- in_valid in 1: input beat valid.
- in_ready out 1: block can accept a beat.
- c0, c1, c2, c3 in IN_W each: signed coefficients, low to high frequency.
- out_valid out 1: output beat valid.
- out_ready in 1: downstream accepts.
- y0, y1, y2, y3 out OUT_W each: signed reconstructed samples.

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high.
- Internal width: IW = IN_W+9, signed; no intermediate overflow at any legal input.
- Stage 1 (registered):
  - E0 = (c0+c2)<<6; E1 = (c0-c2)<<6.
  - O0 = 83*c1 + 36*c3; O1 = 36*c1 - 83*c3.
  - 83x = (x<<6)+(x<<4)+(x<<1)+x; 36x = (x<<5)+(x<<2).
- Stage 2 (registered):
  - y0' = E0+O0; y1' = E1+O1; y2' = E1-O1; y3' = E0-O0.
  - Add rounding offset 1<<(SHIFT-1) to each.
- Stage 3 (registered): arithmetic >>> SHIFT, then range-limit to OUT_W (see Optional Feature); drives y0..y3.
- Pipeline control:
  - Global enable en = !out_valid || out_ready; all three stages and their valid bits advance only when en=1.
  - in_ready = en, combinational from out_valid/out_ready only, never from in_valid.
  - Transfer on in_valid && in_ready.
- Latency: 3 cycles accept-to-out_valid with out_ready held high; throughput 1 beat/cycle.
- Stall:
  - While out_valid && !out_ready, y0..y3 and out_valid hold stable.
  - No beat is dropped or duplicated; order is preserved.
  - Capacity is 3 beats in flight.
- Bubbles: invalid stages propagate as bubbles; data registers of invalid stages may update but are don't-care.
- Reset:
  - All valid bits and y0..y3 go to 0; in_ready = 1 in the cycle after reset.
  - Reset mid-operation discards all in-flight beats with no partial output.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.

Optional Feature:
- Macro IDCT4_CLIP_EN.
- Defined: stage 3 saturates the shifted value to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
- Undefined: stage 3 truncates to the low OUT_W bits (two's-complement wrap), for area-reduced builds where upstream guarantees range.

Decomposition:
- Package idct4_pkg:
  - Kernel constants K64=64, K83=83, K36=36.
  - Function for the internal width (IN_W+9).
  - Typedef for the 4-sample vector.
- Sub-module idct4_mcm_83_36:
  - Combinational shift-add multiple-constant multiplier, input x IN_W, outputs x83 and x36 at IN_W+7.
  - Instantiated twice, for c1 and c3.

Test Plan:
- Reset then c=(64,0,0,0), SHIFT=7, out_ready=1 -> after 3 cycles y=(32,32,32,32), out_valid pulses 1 cycle.
- c=(0,1,0,0) -> y=(1,0,0,-1); checks rounding on negative values (-19>>>7 = -1).
- All c=32767, OUT_W=16 -> with IDCT4_CLIP_EN y0=32767 and y3=2304; without it y0=-2306 (wrap of 63230).
- Back-to-back 8 random beats with out_ready=1 -> 8 consecutive out_valid cycles, every output matches the reference model.
- out_ready=0 for 5 cycles while in_valid=1 with 4 distinct beats offered -> in_ready drops after 3 accepted, y held stable, all 4 emerge in order once out_ready=1.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and y=0 next cycle; in-flight beats never appear.
